mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, address width of all ports.
REQ-002 Parameter DATA_W, default 64, data width; wmask width is DATA_W/8.
REQ-003 Ports; the block SHALL use one clock, and reset is synchronous and active-high:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- ifu_req_valid  in  1  fetch read request.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_resp_valid  out  1  fetch data valid, one-cycle pulse.
- ifu_rdata  out  DATA_W  fetch data.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  load/store request accepted this cycle.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  store byte mask.
- lsu_resp_valid  out  1  load data or store-done, one-cycle pulse.
- lsu_rdata  out  DATA_W  load data; 0 for store responses.
- mem_req_valid  out  1  request to the shared memory port.
- mem_req_ready  in  1  memory accepts the request.
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields.
- mem_resp_valid  in  1  memory response, one cycle.
- mem_rdata  in  DATA_W  memory read data.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; exactly one transaction is outstanding at a time.
REQ-005 In IDLE, when one or both requesters are valid, the block SHALL grant exactly one.
- The granted requester's req_ready is high that cycle, combinationally from req_valid and the arbitration state.
- Its fields and owner id are latched.
- Next state is ISSUE.
REQ-006 Tie-break SHALL be round-robin: with both valid, the requester not granted most recently wins; a single valid requester always wins.
REQ-007 req_ready SHALL be 0 in every state other than IDLE.
- Requesters hold valid and fields stable until ready.
- The block ignores field changes after the latch.
REQ-008 ISSUE: mem_req_valid=1 with latched fields, held stable until mem_req_ready=1; that cycle -> WAIT.
REQ-009 Fetch requests SHALL drive mem_we=0, mem_wdata=0 and mem_wmask=0.
REQ-010 WAIT: on mem_resp_valid=1, capture mem_rdata into the owner's rdata register (0 if store) -> RESP.
REQ-011 RESP: the owner's resp_valid=1 for exactly one cycle -> IDLE; the other requester's resp_valid stays 0.
REQ-012 rdata outputs SHALL hold their last value until the next response to that requester.
REQ-013 mem_resp_valid outside WAIT SHALL be ignored, with no state or data change.
REQ-014 Minimum latency: accept at cycle T -> mem handshake T+1 -> mem_resp T+2 -> resp_valid T+3 -> next accept T+4.
REQ-015 Throughput SHALL be at most one transaction per 4 cycles; memory stall cycles add latency 1:1.
REQ-016 No requester SHALL wait more than one foreign transaction once valid (starvation-free).

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL:
- enter IDLE;
- drop any in-flight transaction with no response pulse;
- set all outputs to 0, including rdata registers and latched fields;
- set last-grant = LSU, so IFU wins the first tie.
REQ-018 A memory response arriving after reset for a dropped transaction SHALL be ignored per REQ-013.

Verification
REQ-019 Single fetch: ifu_addr=0x80000000, memory ready immediately, rdata=0x00000413 one cycle later -> ifu_req_ready at T, mem_req_valid at T+1, ifu_resp_valid pulse with ifu_rdata=0x413 at T+3, lsu_resp_valid stays 0.
REQ-020 Store: lsu_we=1, addr 0x80001000, wdata 0x1122334455667788, wmask 0x0F -> mem fields match exactly, lsu_resp_valid pulse with lsu_rdata=0.
REQ-021 Contention: both valid continuously for 4 grants from reset -> grant order IFU, LSU, IFU, LSU.
REQ-022 Memory backpressure: mem_req_ready low 3 cycles -> mem_req_valid and fields stable for 4 cycles, then resp 3 cycles later than REQ-019.
REQ-023 Reset in WAIT, then mem_resp_valid=1 -> no resp_valid pulse, FSM in IDLE, next IFU request served normally.
REQ-024 Spurious mem_resp_valid in IDLE, rdata=0xDEAD -> no output change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and shared-memory request/response signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic                 lsu_req_valid;
    logic                lsu_req_ready;
    logic                lsu_we;
    logic [ADDR_W-1:0]   lsu_addr;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                lsu_resp_valid;
    logic [DATA_W-1:0]   lsu_rdata;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store, one transaction in flight.
// Minimum 4 cycles accept-to-accept; req_ready only in IDLE, memory stalls extend ISSUE 1:1.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                grant_ifu, grant_lsu;
    logic                owner_lsu_q;
    logic                last_lsu_q;
    logic                lat_we_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_wdata_q;
    logic [DATA_W/8-1:0] lat_wmask_q;
    logic [DATA_W-1:0]   ifu_rdata_q;
    logic [DATA_W-1:0]   lsu_rdata_q;

    always_comb begin
        state_d   = state_q;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst so no handshake completes on a reset edge.
                if (!rst) begin
                    grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu_q);
                    grant_lsu = bus.lsu_req_valid && !grant_ifu;
                    if (grant_ifu || grant_lsu) state_d = ISSUE;
                end
            end
            ISSUE:   if (bus.mem_req_ready) state_d = WAIT;
            WAIT:    if (bus.mem_resp_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b1;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_wmask_q <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_ifu) begin
                owner_lsu_q <= 1'b0;
                last_lsu_q  <= 1'b0;
                lat_we_q    <= 1'b0;
                lat_addr_q  <= bus.ifu_addr;
                lat_wdata_q <= '0;
                lat_wmask_q <= '0;
            end else if (grant_lsu) begin
                owner_lsu_q <= 1'b1;
                last_lsu_q  <= 1'b1;
                lat_we_q    <= bus.lsu_we;
                lat_addr_q  <= bus.lsu_addr;
                lat_wdata_q <= bus.lsu_wdata;
                lat_wmask_q <= bus.lsu_wmask;
            end
            if (state_q == WAIT && bus.mem_resp_valid) begin
                if (owner_lsu_q) lsu_rdata_q <= lat_we_q ? '0 : bus.mem_rdata;
                else             ifu_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;
    assign bus.mem_req_valid  = (state_q == ISSUE);
    assign bus.mem_we         = lat_we_q;
    assign bus.mem_addr       = lat_addr_q;
    assign bus.mem_wdata      = lat_wdata_q;
    assign bus.mem_wmask      = lat_wmask_q;
    assign bus.ifu_resp_valid = (state_q == RESP) && !owner_lsu_q;
    assign bus.lsu_resp_valid = (state_q == RESP) && owner_lsu_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifc ();
    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (.clk(clk), .rst(rst), .bus(ifc));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.ifu_req_valid = 1'b1;  ifc.ifu_addr = 64'h1234;
        ifc.lsu_req_valid = 1'b0;  ifc.lsu_we = 1'b0;
        ifc.lsu_addr = '0;  ifc.lsu_wdata = '0;  ifc.lsu_wmask = '0;
        ifc.mem_req_ready = 1'b0;  ifc.mem_resp_valid = 1'b0;  ifc.mem_rdata = '0;
        step();
        n_checks++; if (ifc.ifu_req_ready !== 1'b0) $display("FAIL reset_ready_in_rst got %0b want 0", ifc.ifu_req_ready); else n_pass++;
        step();
        rst = 1'b0;
        ifc.ifu_req_valid = 1'b0;
        #1;
        n_checks++; if (ifc.mem_req_valid !== 1'b0) $display("FAIL reset_mem_valid got %0b want 0", ifc.mem_req_valid); else n_pass++;
        n_checks++; if (ifc.mem_addr !== 64'h0) $display("FAIL reset_mem_addr got %h want 0", ifc.mem_addr); else n_pass++;
        n_checks++; if ({ifc.ifu_resp_valid, ifc.lsu_resp_valid} !== 2'b00) $display("FAIL reset_resp got %b want 00", {ifc.ifu_resp_valid, ifc.lsu_resp_valid}); else n_pass++;
        n_checks++; if (ifc.ifu_rdata !== 64'h0 || ifc.lsu_rdata !== 64'h0) $display("FAIL reset_rdata got %h/%h want 0/0", ifc.ifu_rdata, ifc.lsu_rdata); else n_pass++;
    endtask

    task automatic test_single_fetch();
        ifc.ifu_req_valid = 1'b1;  ifc.ifu_addr = 64'h8000_0000;
        #1;
        n_checks++; if ({ifc.ifu_req_ready, ifc.lsu_req_ready} !== 2'b10) $display("FAIL fetch_accept got %b want 10", {ifc.ifu_req_ready, ifc.lsu_req_ready}); else n_pass++;
        step();
        ifc.ifu_req_valid = 1'b0;  ifc.ifu_addr = 64'hFFFF_0000;
        ifc.mem_req_ready = 1'b1;
        #1;
        n_checks++; if (ifc.mem_req_valid !== 1'b1) $display("FAIL fetch_mem_valid got %0b want 1", ifc.mem_req_valid); else n_pass++;
        n_checks++; if (ifc.mem_addr !== 64'h8000_0000) $display("FAIL fetch_mem_addr got %h want 80000000", ifc.mem_addr); else n_pass++;
        n_checks++; if ({ifc.mem_we, ifc.mem_wmask, ifc.mem_wdata} !== 73'h0) $display("FAIL fetch_mem_fields got we=%0b mask=%h wdata=%h want zeros", ifc.mem_we, ifc.mem_wmask, ifc.mem_wdata); else n_pass++;
        step();
        ifc.mem_req_ready = 1'b0;
        ifc.mem_resp_valid = 1'b1;  ifc.mem_rdata = 64'h413;
        #1;
        n_checks++; if (ifc.mem_req_valid !== 1'b0 || ifc.ifu_resp_valid !== 1'b0) $display("FAIL fetch_wait got mem_valid=%0b resp=%0b want 0/0", ifc.mem_req_valid, ifc.ifu_resp_valid); else n_pass++;
        step();
        ifc.mem_resp_valid = 1'b0;  ifc.mem_rdata = 64'h0;
        #1;
        n_checks++; if (ifc.ifu_resp_valid !== 1'b1 || ifc.ifu_rdata !== 64'h413) $display("FAIL fetch_resp got v=%0b d=%h want 1/413", ifc.ifu_resp_valid, ifc.ifu_rdata); else n_pass++;
        n_checks++; if (ifc.lsu_resp_valid !== 1'b0) $display("FAIL fetch_lsu_quiet got %0b want 0", ifc.lsu_resp_valid); else n_pass++;
        step();
        n_checks++; if (ifc.ifu_resp_valid !== 1'b0 || ifc.ifu_rdata !== 64'h413) $display("FAIL fetch_pulse_hold got v=%0b d=%h want 0/413", ifc.ifu_resp_valid, ifc.ifu_rdata); else n_pass++;
    endtask

    task automatic test_store();
        ifc.lsu_req_valid = 1'b1;  ifc.lsu_we = 1'b1;
        ifc.lsu_addr = 64'h8000_1000;  ifc.lsu_wdata = 64'h1122_3344_5566_7788;  ifc.lsu_wmask = 8'h0F;
        #1;
        n_checks++; if ({ifc.ifu_req_ready, ifc.lsu_req_ready} !== 2'b01) $display("FAIL store_accept got %b want 01", {ifc.ifu_req_ready, ifc.lsu_req_ready}); else n_pass++;
        step();
        ifc.lsu_req_valid = 1'b0;  ifc.lsu_wdata = 64'h0;  ifc.lsu_wmask = 8'hFF;
        ifc.mem_req_ready = 1'b1;
        #1;
        n_checks++; if ({ifc.mem_req_valid, ifc.mem_we} !== 2'b11) $display("FAIL store_mem_valid_we got %b want 11", {ifc.mem_req_valid, ifc.mem_we}); else n_pass++;
        n_checks++; if (ifc.mem_addr !== 64'h8000_1000 || ifc.mem_wdata !== 64'h1122_3344_5566_7788 || ifc.mem_wmask !== 8'h0F)
            $display("FAIL store_mem_fields got a=%h d=%h m=%h want 80001000/1122334455667788/0f", ifc.mem_addr, ifc.mem_wdata, ifc.mem_wmask); else n_pass++;
        step();
        ifc.mem_req_ready = 1'b0;
        ifc.mem_resp_valid = 1'b1;  ifc.mem_rdata = 64'hAAAA;
        step();
        ifc.mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (ifc.lsu_resp_valid !== 1'b1 || ifc.lsu_rdata !== 64'h0) $display("FAIL store_resp got v=%0b d=%h want 1/0", ifc.lsu_resp_valid, ifc.lsu_rdata); else n_pass++;
        n_checks++; if (ifc.ifu_resp_valid !== 1'b0 || ifc.ifu_rdata !== 64'h413) $display("FAIL store_ifu_quiet got v=%0b d=%h want 0/413", ifc.ifu_resp_valid, ifc.ifu_rdata); else n_pass++;
        step();
    endtask

    task automatic test_contention();
        logic exp_lsu;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifc.ifu_req_valid = 1'b1;  ifc.ifu_addr = 64'h100;
        ifc.lsu_req_valid = 1'b1;  ifc.lsu_we = 1'b0;  ifc.lsu_addr = 64'h200;
        ifc.lsu_wdata = 64'h5555;  ifc.lsu_wmask = 8'h33;
        for (int g = 0; g < 4; g++) begin
            exp_lsu = (g % 2 == 1);
            #1;
            n_checks++; if ({ifc.ifu_req_ready, ifc.lsu_req_ready} !== {!exp_lsu, exp_lsu}) $display("FAIL contention_grant%0d got %b want %b", g, {ifc.ifu_req_ready, ifc.lsu_req_ready}, {!exp_lsu, exp_lsu}); else n_pass++;
            step();
            ifc.mem_req_ready = 1'b1;
            #1;
            n_checks++; if (ifc.mem_addr !== (exp_lsu ? 64'h200 : 64'h100)) $display("FAIL contention_addr%0d got %h want %h", g, ifc.mem_addr, exp_lsu ? 64'h200 : 64'h100); else n_pass++;
            n_checks++; if ({ifc.ifu_req_ready, ifc.lsu_req_ready} !== 2'b00) $display("FAIL contention_busy%0d got %b want 00", g, {ifc.ifu_req_ready, ifc.lsu_req_ready}); else n_pass++;
            step();
            ifc.mem_req_ready = 1'b0;
            ifc.mem_resp_valid = 1'b1;  ifc.mem_rdata = 64'(g + 16);
            step();
            ifc.mem_resp_valid = 1'b0;
            #1;
            n_checks++; if ({ifc.ifu_resp_valid, ifc.lsu_resp_valid} !== {!exp_lsu, exp_lsu}) $display("FAIL contention_resp%0d got %b want %b", g, {ifc.ifu_resp_valid, ifc.lsu_resp_valid}, {!exp_lsu, exp_lsu}); else n_pass++;
            step();
            if (g == 3) begin
                ifc.ifu_req_valid = 1'b0;
                ifc.lsu_req_valid = 1'b0;
            end
        end
        #1;
        n_checks++; if (ifc.ifu_rdata !== 64'd18 || ifc.lsu_rdata !== 64'd19) $display("FAIL contention_rdata got %h/%h want 12/13", ifc.ifu_rdata, ifc.lsu_rdata); else n_pass++;
    endtask

    task automatic test_backpressure();
        ifc.ifu_req_valid = 1'b1;  ifc.ifu_addr = 64'h8000_0004;
        #1;
        n_checks++; if (ifc.ifu_req_ready !== 1'b1) $display("FAIL bp_accept got %0b want 1", ifc.ifu_req_ready); else n_pass++;
        step();
        ifc.ifu_req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ifc.ifu_addr = 64'(c);
            ifc.mem_req_ready = (c == 3);
            #1;
            n_checks++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_addr !== 64'h8000_0004 || ifc.mem_we !== 1'b0)
                $display("FAIL bp_hold%0d got v=%0b a=%h we=%0b want 1/80000004/0", c, ifc.mem_req_valid, ifc.mem_addr, ifc.mem_we); else n_pass++;
            step();
        end
        ifc.mem_req_ready = 1'b0;
        ifc.mem_resp_valid = 1'b1;  ifc.mem_rdata = 64'h13;
        #1;
        n_checks++; if (ifc.mem_req_valid !== 1'b0 || ifc.ifu_resp_valid !== 1'b0) $display("FAIL bp_wait got v=%0b r=%0b want 0/0", ifc.mem_req_valid, ifc.ifu_resp_valid); else n_pass++;
        step();
        ifc.mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (ifc.ifu_resp_valid !== 1'b1 || ifc.ifu_rdata !== 64'h13) $display("FAIL bp_resp got v=%0b d=%h want 1/13", ifc.ifu_resp_valid, ifc.ifu_rdata); else n_pass++;
        step();
    endtask

    task automatic test_reset_in_wait();
        ifc.ifu_req_valid = 1'b1;  ifc.ifu_addr = 64'h8000_0008;
        step();
        ifc.ifu_req_valid = 1'b0;
        ifc.mem_req_ready = 1'b1;
        step();
        ifc.mem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifc.mem_resp_valid = 1'b1;  ifc.mem_rdata = 64'hBEEF;
        #1;
        n_checks++; if (ifc.ifu_resp_valid !== 1'b0 || ifc.mem_req_valid !== 1'b0 || ifc.ifu_rdata !== 64'h0)
            $display("FAIL rstwait_after got r=%0b v=%0b d=%h want 0/0/0", ifc.ifu_resp_valid, ifc.mem_req_valid, ifc.ifu_rdata); else n_pass++;
        step();
        ifc.mem_resp_valid = 1'b0;
        ifc.ifu_req_valid = 1'b1;  ifc.ifu_addr = 64'h8000_000C;
        #1;
        n_checks++; if (ifc.ifu_resp_valid !== 1'b0 || ifc.ifu_rdata !== 64'h0 || ifc.ifu_req_ready !== 1'b1)
            $display("FAIL rstwait_idle got r=%0b d=%h rdy=%0b want 0/0/1", ifc.ifu_resp_valid, ifc.ifu_rdata, ifc.ifu_req_ready); else n_pass++;
        step();
        ifc.ifu_req_valid = 1'b0;
        ifc.mem_req_ready = 1'b1;
        #1;
        n_checks++; if (ifc.mem_addr !== 64'h8000_000C) $display("FAIL rstwait_addr got %h want 8000000c", ifc.mem_addr); else n_pass++;
        step();
        ifc.mem_req_ready = 1'b0;
        ifc.mem_resp_valid = 1'b1;  ifc.mem_rdata = 64'h55;
        step();
        ifc.mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (ifc.ifu_resp_valid !== 1'b1 || ifc.ifu_rdata !== 64'h55) $display("FAIL rstwait_resp got v=%0b d=%h want 1/55", ifc.ifu_resp_valid, ifc.ifu_rdata); else n_pass++;
        step();
    endtask

    task automatic test_spurious();
        ifc.mem_resp_valid = 1'b1;  ifc.mem_rdata = 64'hDEAD;
        step();
        ifc.mem_resp_valid = 1'b0;
        #1;
        n_checks++; if ({ifc.ifu_resp_valid, ifc.lsu_resp_valid, ifc.mem_req_valid} !== 3'b000) $display("FAIL spur_valids got %b want 000", {ifc.ifu_resp_valid, ifc.lsu_resp_valid, ifc.mem_req_valid}); else n_pass++;
        n_checks++; if (ifc.ifu_rdata !== 64'h55 || ifc.lsu_rdata !== 64'h0) $display("FAIL spur_rdata got %h/%h want 55/0", ifc.ifu_rdata, ifc.lsu_rdata); else n_pass++;
        ifc.lsu_req_valid = 1'b1;  ifc.lsu_we = 1'b0;  ifc.lsu_addr = 64'h300;
        #1;
        n_checks++; if (ifc.lsu_req_ready !== 1'b1) $display("FAIL spur_still_idle got %0b want 1", ifc.lsu_req_ready); else n_pass++;
        step();
        ifc.lsu_req_valid = 1'b0;
        ifc.mem_req_ready = 1'b1;
        step();
        ifc.mem_req_ready = 1'b0;
        ifc.mem_resp_valid = 1'b1;  ifc.mem_rdata = 64'h77;
        step();
        ifc.mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (ifc.lsu_resp_valid !== 1'b1 || ifc.lsu_rdata !== 64'h77) $display("FAIL spur_load got v=%0b d=%h want 1/77", ifc.lsu_resp_valid, ifc.lsu_rdata); else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_backpressure();
        test_reset_in_wait();
        test_spurious();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
